// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for an async FIFO: first-word-fall-through head register
// fed from a one-cycle-latency RAM, with Gray pointer export and fill count.
//   state   | meaning
//   S_IDLE  | no word held or in flight
//   S_FETCH | RAM read in flight, data captured at end of cycle
//   S_VALID | head word held on rd_data_o
module fifo_rd_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH:0]   wr_ptr_gray_i,
  input  logic                  rd_en_i,
  input  logic [DATA_WIDTH-1:0] ram_rd_data_i,
  output logic                  ram_rd_en_o,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  empty_o,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray_o,
  output logic [ADDR_WIDTH:0]   rd_count_o,
  output logic                  underflow_o
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_VALID} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH:0]   w_wr_bin;
  logic [ADDR_WIDTH:0]   r_rd_bin;
  logic [ADDR_WIDTH:0]   w_rd_bin_nxt;
  logic [ADDR_WIDTH:0]   r_rd_ptr_gray;
  logic [ADDR_WIDTH:0]   r_rd_count;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_underflow;
  logic                  w_issue;
  logic                  w_avail;
  logic                  w_underflow;

  // Binary bit i is the XOR of all Gray bits at or above i.
  for (genvar gi = 0; gi <= ADDR_WIDTH; gi++) begin : g_gray2bin
    assign w_wr_bin[gi] = ^(wr_ptr_gray_i >> gi);
  end

  assign w_avail      = (w_wr_bin != r_rd_bin);
  assign w_rd_bin_nxt = r_rd_bin + {{ADDR_WIDTH{1'b0}}, w_issue};
  assign w_underflow  = rd_en_i & (r_state != S_VALID);

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_avail) begin
          w_issue     = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: w_state_nxt = S_VALID;
      S_VALID: begin
        if (rd_en_i) begin
          if (w_avail) begin
            w_issue     = 1'b1;
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_rd_bin      <= '0;
      r_rd_ptr_gray <= '0;
      r_rd_count    <= '0;
      r_rd_data     <= '0;
      r_underflow   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_rd_bin      <= w_rd_bin_nxt;
      r_rd_ptr_gray <= (w_rd_bin_nxt >> 1) ^ w_rd_bin_nxt;
      r_rd_count    <= w_wr_bin - w_rd_bin_nxt;
      r_underflow   <= w_underflow;
      if (r_state == S_FETCH) r_rd_data <= ram_rd_data_i;
    end
  end

  // The strobe is combinational, so it is gated to keep the RAM quiet in reset.
  assign ram_rd_en_o   = w_issue & ~rst_i;
  assign ram_rd_addr_o = r_rd_bin[ADDR_WIDTH-1:0];
  assign rd_data_o     = r_rd_data;
  assign rd_valid_o    = (r_state == S_VALID);
  assign empty_o       = ~rd_valid_o;
  assign rd_ptr_gray_o = r_rd_ptr_gray;
  assign rd_count_o    = r_rd_count;
  assign underflow_o   = r_underflow;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: a behavioural write side and RAM feed the DUT,
// and a queue of written words is checked against every pop.
module tb_fifo_rd_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [4:0] wr_ptr_gray_i;
  logic       rd_en_i;
  logic [7:0] ram_rd_data_i;
  logic       ram_rd_en_o;
  logic [3:0] ram_rd_addr_o;
  logic [7:0] rd_data_o;
  logic       rd_valid_o;
  logic       empty_o;
  logic [4:0] rd_ptr_gray_o;
  logic [4:0] rd_count_o;
  logic       underflow_o;

  fifo_rd_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .wr_ptr_gray_i (wr_ptr_gray_i),
    .rd_en_i       (rd_en_i),
    .ram_rd_data_i (ram_rd_data_i),
    .ram_rd_en_o   (ram_rd_en_o),
    .ram_rd_addr_o (ram_rd_addr_o),
    .rd_data_o     (rd_data_o),
    .rd_valid_o    (rd_valid_o),
    .empty_o       (empty_o),
    .rd_ptr_gray_o (rd_ptr_gray_o),
    .rd_count_o    (rd_count_o),
    .underflow_o   (underflow_o)
  );

  always #5 clk_i = ~clk_i;

  logic [7:0] ram [16];
  logic [4:0] wr_bin;
  logic [7:0] q[$];
  int         n_assert = 0;
  int         n_fail   = 0;
  int         n_pops   = 0;

  always @(posedge clk_i) if (ram_rd_en_o) ram_rd_data_i <= ram[ram_rd_addr_o];

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    ram[wr_bin[3:0]] = d;
    wr_bin           = wr_bin + 5'd1;
    wr_ptr_gray_i    = gray(wr_bin);
    q.push_back(d);
  endtask

  // One clock: scoreboard check of any pop happening this cycle, then step past the edge.
  task automatic cyc();
    logic [7:0] exp_d;
    #1;
    if (rd_en_i && rd_valid_o) begin
      if (q.size() == 0) begin
        chk("pop_unexpected", 32'd1, 32'd0);
      end else begin
        exp_d = q.pop_front();
        chk("pop_data", {24'd0, rd_data_o}, {24'd0, exp_d});
        n_pops++;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops0;
    rst_i         = 1'b1;
    wr_bin        = '0;
    wr_ptr_gray_i = '0;
    rd_en_i       = 1'b0;
    ram_rd_data_i = '0;
    for (int i = 0; i < 16; i++) ram[i] = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_valid", rd_valid_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_gray", rd_ptr_gray_o, 0);
    chk("rst_count", rd_count_o, 0);
    chk("rst_data", rd_data_o, 0);
    chk("rst_uflow", underflow_o, 0);
    chk("rst_ramen", ram_rd_en_o, 0);
    rst_i = 1'b0;
    cyc();

    // First word latency
    push(8'hA5);
    #1;
    chk("c0_ramen", ram_rd_en_o, 1);
    chk("c0_addr", ram_rd_addr_o, 0);
    cyc();
    chk("c1_valid", rd_valid_o, 0);
    chk("c1_ramen", ram_rd_en_o, 0);
    chk("c1_gray", rd_ptr_gray_o, 5'b00001);
    cyc();
    chk("c2_valid", rd_valid_o, 1);
    chk("c2_data", rd_data_o, 8'hA5);
    chk("c2_gray", rd_ptr_gray_o, 5'b00001);
    chk("c2_empty", empty_o, 0);
    cyc();
    chk("hold_data", rd_data_o, 8'hA5);
    chk("hold_valid", rd_valid_o, 1);
    rd_en_i = 1'b1;
    cyc();
    chk("pop_empty", empty_o, 1);
    chk("pop_count", rd_count_o, 0);

    // Underflow: one-cycle pop request while empty
    cyc();
    rd_en_i = 1'b0;
    chk("uflow_hi", underflow_o, 1);
    chk("uflow_count", rd_count_o, 0);
    chk("uflow_gray", rd_ptr_gray_o, 5'b00001);
    cyc();
    chk("uflow_lo", underflow_o, 0);
    chk("uflow_ramen", ram_rd_en_o, 0);

    // Full RAM from reset, drained with rd_en held high
    rst_i  = 1'b1;
    wr_bin = '0;
    q.delete();
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i * 7));
    #1;
    chk("full_wrgray", wr_ptr_gray_i, 5'b11000);
    chk("full_rst_ramen", ram_rd_en_o, 0);
    cyc();
    rst_i   = 1'b0;
    rd_en_i = 1'b1;
    #1;
    chk("full_c0_ramen", ram_rd_en_o, 1);
    chk("full_c0_addr", ram_rd_addr_o, 0);
    cyc();
    chk("full_c1_count", rd_count_o, 15);
    pops0 = n_pops;
    for (int i = 0; i < 33; i++) cyc();
    rd_en_i = 1'b0;
    chk("full_pops", n_pops - pops0, 16);
    chk("full_empty", empty_o, 1);
    chk("full_count", rd_count_o, 0);
    chk("full_gray", rd_ptr_gray_o, 5'b11000);

    // Wrap of rd_bin 31 -> 0 and address 15 -> 0
    for (int i = 0; i < 15; i++) push(8'h80 + 8'(i));
    rd_en_i = 1'b1;
    for (int i = 0; i < 40 && q.size() != 0; i++) cyc();
    rd_en_i = 1'b0;
    chk("wrap_drain", q.size(), 0);
    chk("wrap_pre_gray", rd_ptr_gray_o, 5'b10000);
    push(8'h5A);
    #1;
    chk("wrap_ramen15", ram_rd_en_o, 1);
    chk("wrap_addr15", ram_rd_addr_o, 15);
    cyc();
    chk("wrap_gray0", rd_ptr_gray_o, 5'b00000);
    push(8'hC3);
    cyc();
    rd_en_i = 1'b1;
    #1;
    chk("wrap_ramen0", ram_rd_en_o, 1);
    chk("wrap_addr0", ram_rd_addr_o, 0);
    cyc();
    chk("wrap_gray1", rd_ptr_gray_o, 5'b00001);
    for (int i = 0; i < 4 && q.size() != 0; i++) cyc();
    rd_en_i = 1'b0;
    chk("wrap_done", q.size(), 0);

    // Reset while a fetch is in flight
    push(8'h3C);
    cyc();
    chk("mid_fetch_valid", rd_valid_o, 0);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_valid", rd_valid_o, 0);
    chk("mid_rst_empty", empty_o, 1);
    chk("mid_rst_gray", rd_ptr_gray_o, 0);
    chk("mid_rst_count", rd_count_o, 0);
    cyc();
    chk("mid_no_capture", rd_data_o, 0);
    chk("mid_valid_after", rd_valid_o, 0);
    wr_bin = '0;
    q.delete();
    push(8'h77);
    #1;
    chk("mid_rst_ramen", ram_rd_en_o, 0);
    cyc();
    rst_i = 1'b0;
    #1;
    chk("restart_ramen", ram_rd_en_o, 1);
    chk("restart_addr", ram_rd_addr_o, 0);
    cyc();
    cyc();
    chk("restart_valid", rd_valid_o, 1);
    rd_en_i = 1'b1;
    cyc();
    rd_en_i = 1'b0;
    chk("restart_done", q.size(), 0);
    chk("restart_empty", empty_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
